// File: rtl/seq_detect_param.sv
// Runtime-configurable serial bit-sequence detector with valid qualification,
// overlap control, Mealy/Moore output timing and a saturating match counter.
module seq_detect_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(8'b0001_0001),
  parameter int                 DEFAULT_LEN = 5,
  localparam int                LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  input  logic               in_i,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LW-1:0]      cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic               cfg_mealy_i,
  input  logic               count_clr_i,
  output logic               out_o,
  output logic [CNT_W-1:0]   match_count_o
);

  localparam logic [LW-1:0]    MAX_LEN_W = LW'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               mealy_q, mealy_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic               moore_q, moore_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] hist_ext;
  logic [MAX_LEN-1:0] mask;
  logic               fill_ok;
  logic               match;

  // Window of the newest bits including the one on the pin this cycle.
  assign hist_ext = {hist_q[MAX_LEN-2:0], in_i};

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < len_q) mask[i] = 1'b1;
    end
    fill_ok = ({1'b0, fill_q} + {{LW{1'b0}}, 1'b1}) >= {1'b0, len_q};
    match   = in_valid_i & ~cfg_load_i & (len_q != '0) & fill_ok &
              (((hist_ext ^ pat_q) & mask) == '0);
  end

  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    mealy_d = mealy_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    moore_d = match;
    cnt_d   = cnt_q;

    if (cfg_load_i) begin
      pat_d   = cfg_pattern_i;
      len_d   = (cfg_len_i > MAX_LEN_W) ? MAX_LEN_W : cfg_len_i;
      ovl_d   = cfg_overlap_i;
      mealy_d = cfg_mealy_i;
      hist_d  = '0;
      fill_d  = '0;
      moore_d = 1'b0;
    end else if (in_valid_i) begin
      hist_d = hist_ext;
      if (match && !ovl_q) fill_d = '0;
      else if (fill_q != MAX_LEN_W) fill_d = fill_q + LW'(1);
    end

    // Clear wins over a simultaneous match.
    if (count_clr_i) cnt_d = '0;
    else if (match && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pat_q   <= DEFAULT_PAT;
      len_q   <= LW'(DEFAULT_LEN);
      ovl_q   <= 1'b1;
      mealy_q <= 1'b1;
      hist_q  <= '0;
      fill_q  <= '0;
      moore_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      mealy_q <= mealy_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      moore_q <= moore_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_o         = mealy_q ? match : moore_q;
  assign match_count_o = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed tables, corner sequences and a random
// run checked against a bit-queue reference model.
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LW      = 4;
  localparam int CMAX    = 15;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid, in_bit, cfg_load, cfg_overlap, cfg_mealy, count_clr;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               out;
  logic [CNT_W-1:0]   match_count;

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_i         (in_bit),
    .cfg_load_i   (cfg_load),
    .cfg_pattern_i(cfg_pattern),
    .cfg_len_i    (cfg_len),
    .cfg_overlap_i(cfg_overlap),
    .cfg_mealy_i  (cfg_mealy),
    .count_clr_i  (count_clr),
    .out_o        (out),
    .match_count_o(match_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the valid bits seen since the last clear, plus config.
  bit         bq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl, m_mly, m_moore;
  int         m_cnt;

  // Values presented on the cfg pins when a load is issued.
  logic [7:0] c_pat;
  int         c_len;
  bit         c_ovl, c_mly;

  typedef struct {
    logic v;
    logic b;
    int   eo;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    m_pat = 8'b0001_0001; m_len = 5; m_ovl = 1; m_mly = 1; m_moore = 0; m_cnt = 0;
  endtask

  function automatic bit model_match(bit v, bit b, bit ld);
    bit r;
    if (!v || ld || m_len == 0) return 0;
    if (bq.size() + 1 < m_len) return 0;
    for (int k = 0; k < m_len; k++) begin
      r = (k == 0) ? b : bq[bq.size() - k];
      if (r != m_pat[k]) return 0;
    end
    return 1;
  endfunction

  // One clock: drive at posedge+1, check before the next edge, then advance the model.
  task automatic tick(input bit v, input bit b, input bit ld, input bit clr,
                      input int eo, input string tag);
    bit m, e;
    in_valid = v; in_bit = b; cfg_load = ld; count_clr = clr;
    cfg_pattern = c_pat; cfg_len = LW'(c_len); cfg_overlap = c_ovl; cfg_mealy = c_mly;
    @(negedge clk);
    m = model_match(v, b, ld);
    e = m_mly ? m : m_moore;
    chk({tag, ".out"}, int'(out), int'(e));
    chk({tag, ".cnt"}, int'(match_count), m_cnt);
    if (eo >= 0) chk({tag, ".tbl"}, int'(out), eo);
    @(posedge clk);
    if (ld) begin
      bq.delete();
      m_pat = c_pat; m_len = (c_len > MAX_LEN) ? MAX_LEN : c_len;
      m_ovl = c_ovl; m_mly = c_mly;
    end else if (v) begin
      bq.push_back(b);
      if (m && !m_ovl) bq.delete();
      if (bq.size() > 16) void'(bq.pop_front());
    end
    if (clr) m_cnt = 0;
    else if (m && m_cnt < CMAX) m_cnt++;
    m_moore = m;
    #1;
  endtask

  task automatic load(input logic [7:0] p, input int l, input bit o, input bit y, input bit clr);
    c_pat = p; c_len = l; c_ovl = o; c_mly = y;
    tick(0, 0, 1, clr, -1, "load");
  endtask

  task automatic run_tbl(input vec_t t[], input string tag);
    foreach (t[i]) tick(t[i].v, t[i].b, 0, 0, t[i].eo, $sformatf("%s[%0d]", tag, i));
  endtask

  initial begin
    vec_t s1[]  = '{'{1,1,0}, '{1,0,0}, '{1,0,0}, '{1,0,0}, '{1,1,1},
                    '{1,0,0}, '{1,0,0}, '{1,0,0}, '{1,1,1}};
    vec_t s2a[] = '{'{1,1,0}, '{1,0,0}, '{1,1,0}, '{1,0,1}, '{1,1,0}, '{1,0,0}};
    vec_t s2b[] = '{'{1,1,0}, '{1,0,0}, '{1,1,0}, '{1,0,1}, '{1,1,0}, '{1,0,1}};
    vec_t s3[]  = '{'{1,1,0}, '{1,0,0}, '{1,0,0}, '{1,0,0}, '{1,1,0},
                    '{1,0,1}, '{1,0,0}, '{1,0,0}, '{1,1,0}, '{0,0,1}, '{0,0,0}};
    vec_t s4[]  = '{'{1,1,0}, '{1,0,0}, '{0,1,0}, '{0,0,0}, '{0,1,0},
                    '{1,0,0}, '{1,0,0}, '{1,1,1}};

    rst_n = 0; in_valid = 0; in_bit = 0; cfg_load = 0; count_clr = 0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; cfg_mealy = 0;
    c_pat = 8'h11; c_len = 5; c_ovl = 1; c_mly = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out", int'(out), 0);
    chk("reset.cnt", int'(match_count), 0);
    rst_n = 1;

    run_tbl(s1, "dflt");
    chk("dflt.cnt_end", int'(match_count), 2);

    load(8'b1010, 4, 0, 1, 1);
    run_tbl(s2a, "novl");
    chk("novl.cnt_end", int'(match_count), 1);
    load(8'b1010, 4, 1, 1, 0);
    run_tbl(s2b, "ovl");
    chk("ovl.cnt_end", int'(match_count), 3);

    load(8'h11, 5, 1, 0, 0);
    run_tbl(s3, "moore");

    load(8'h11, 5, 1, 1, 0);
    run_tbl(s4, "gap");

    // Random traffic with occasional reconfiguration and clears.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 39) == 0)
        load(8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                                                       : $urandom_range(1, 4),
             1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      else
        tick(1'($urandom_range(0, 3) != 0), 1'($urandom), 0,
             $urandom_range(0, 59) == 0, -1, "rnd");
    end

    // Saturation: pattern 11 with overlap matches on every bit after the first.
    load(8'b11, 2, 1, 1, 1);
    for (int i = 0; i < 18; i++) tick(1, 1, 0, 0, (i == 0) ? 0 : 1, "sat");
    chk("sat.cnt", int'(match_count), 15);
    tick(1, 1, 0, 1, 1, "sat.clr");
    chk("sat.clr_cnt", int'(match_count), 0);

    // Asynchronous reset in the middle of a completing bit.
    load(8'h11, 5, 1, 1, 0);
    tick(1, 1, 0, 0, 0, "ar"); tick(1, 0, 0, 0, 0, "ar");
    tick(1, 0, 0, 0, 0, "ar"); tick(1, 0, 0, 0, 0, "ar");
    in_valid = 1; in_bit = 1;
    #2;
    chk("ar.pre_out", int'(out), 1);
    rst_n = 0;
    #1;
    chk("ar.out", int'(out), 0);
    chk("ar.cnt", int'(match_count), 0);
    model_reset();
    c_pat = 8'h00; c_len = 3; c_ovl = 0; c_mly = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    tick(1, 1, 0, 0, 0, "ar.post");
    tick(1, 0, 0, 0, 0, "ar.post"); tick(1, 0, 0, 0, 0, "ar.post");
    tick(1, 0, 0, 0, 0, "ar.post"); tick(1, 1, 0, 0, 1, "ar.dflt");
    chk("ar.cnt_end", int'(match_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
